// File: rtl/umi_isolate_pkg.sv
// Shared types and default constants for the UMI isolation controller.
package umi_isolate_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ISO   = 2'd2,
    WAKE  = 2'd3
  } iso_state_e;

  localparam int DEF_N             = 2;
  localparam int DEF_CW            = 32;
  localparam int DEF_AW            = 64;
  localparam int DEF_DW            = 256;
  localparam int DEF_WAKE_CYCLES   = 4;
  localparam int DEF_DRAIN_TIMEOUT = 64;

  // Width of a counter that must hold 0..max inclusive.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/umi_isolate_chan.sv
// One UMI channel: pass-through when open, otherwise all outputs forced to 0.
// Also produces the next value of the channel's pending-offer bit.
module umi_isolate_chan #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
) (
  input  logic          pass,
  input  logic          pend,
  output logic          pend_nxt,
  input  logic          in_valid,
  input  logic [CW-1:0] in_cmd,
  input  logic [AW-1:0] in_dstaddr,
  input  logic [AW-1:0] in_srcaddr,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_cmd,
  output logic [AW-1:0] out_dstaddr,
  output logic [AW-1:0] out_srcaddr,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  assign out_valid   = pass & in_valid;
  assign out_cmd     = pass ? in_cmd     : '0;
  assign out_dstaddr = pass ? in_dstaddr : '0;
  assign out_srcaddr = pass ? in_srcaddr : '0;
  assign out_data    = pass ? in_data    : '0;
  assign in_ready    = pass & out_ready;

  // A visible offer that is not taken stays owed; a handshake settles it.
  assign pend_nxt = out_valid ? ~out_ready : pend;

endmodule

// File: rtl/umi_isolate_ctrl.sv
// Isolation controller for N UMI channels: RUN -> DRAIN -> ISO -> WAKE -> RUN.
// Owed offers are allowed to finish before the channels are clamped.
module umi_isolate_ctrl
  import umi_isolate_pkg::*;
#(
  parameter int N             = DEF_N,
  parameter int CW            = DEF_CW,
  parameter int AW            = DEF_AW,
  parameter int DW            = DEF_DW,
  parameter int WAKE_CYCLES   = DEF_WAKE_CYCLES,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            iso_req,
  output logic            iso_ack,
  output logic            drain_err,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic [N-1:0]    umi_out_valid,
  output logic [N*CW-1:0] umi_out_cmd,
  output logic [N*AW-1:0] umi_out_dstaddr,
  output logic [N*AW-1:0] umi_out_srcaddr,
  output logic [N*DW-1:0] umi_out_data,
  input  logic [N-1:0]    umi_out_ready
);

  localparam int DCW = cnt_w(DRAIN_TIMEOUT);
  localparam int WCW = cnt_w(WAKE_CYCLES);
  localparam logic [DCW-1:0] DRAIN_MAX  = DCW'(DRAIN_TIMEOUT);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);
  localparam logic [WCW-1:0] WAKE_LOAD  = WCW'(WAKE_CYCLES);
  localparam logic [WCW-1:0] WAKE_ONE   = WCW'(1);

  iso_state_e     state, state_nxt;
  logic [N-1:0]   pend, pend_nxt, pass;
  logic [DCW-1:0] drain_cnt, drain_cnt_nxt;
  logic [WCW-1:0] wake_cnt, wake_cnt_nxt;
  logic           set_err;

  assign pass = {N{state == RUN}} | ({N{state == DRAIN}} & pend);

  for (genvar i = 0; i < N; i++) begin : g_chan
    umi_isolate_chan #(.CW(CW), .AW(AW), .DW(DW)) u_chan (
      .pass        (pass[i]),
      .pend        (pend[i]),
      .pend_nxt    (pend_nxt[i]),
      .in_valid    (umi_in_valid[i]),
      .in_cmd      (umi_in_cmd[i*CW +: CW]),
      .in_dstaddr  (umi_in_dstaddr[i*AW +: AW]),
      .in_srcaddr  (umi_in_srcaddr[i*AW +: AW]),
      .in_data     (umi_in_data[i*DW +: DW]),
      .in_ready    (umi_in_ready[i]),
      .out_valid   (umi_out_valid[i]),
      .out_cmd     (umi_out_cmd[i*CW +: CW]),
      .out_dstaddr (umi_out_dstaddr[i*AW +: AW]),
      .out_srcaddr (umi_out_srcaddr[i*AW +: AW]),
      .out_data    (umi_out_data[i*DW +: DW]),
      .out_ready   (umi_out_ready[i])
    );
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    wake_cnt_nxt  = wake_cnt;
    set_err       = 1'b0;
    unique case (state)
      RUN: begin
        if (iso_req) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt != DRAIN_MAX) drain_cnt_nxt = drain_cnt + 1'b1;
        // Leave as soon as the last owed handshake lands, even in this cycle.
        if (~|pend_nxt) begin
          state_nxt = ISO;
        end else if (drain_cnt >= DRAIN_LAST) begin
          state_nxt = ISO;
          set_err   = 1'b1;
        end
      end
      ISO: begin
        if (!iso_req) begin
          state_nxt    = WAKE;
          wake_cnt_nxt = WAKE_LOAD;
        end
      end
      WAKE: begin
        if (wake_cnt != '0) wake_cnt_nxt = wake_cnt - 1'b1;
        if (iso_req) state_nxt = ISO;
        else if (wake_cnt <= WAKE_ONE) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= RUN;
      pend      <= '0;
      drain_cnt <= '0;
      wake_cnt  <= '0;
      iso_ack   <= 1'b0;
      drain_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend      <= (state == ISO) ? '0 : pend_nxt;
      drain_cnt <= drain_cnt_nxt;
      wake_cnt  <= wake_cnt_nxt;
      iso_ack   <= (state == ISO);
      if (set_err) drain_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_umi_isolate_ctrl.sv
// Self-checking bench for umi_isolate_ctrl: random traffic against a phase model
// plus a per-channel scoreboard of accepted versus delivered transfers.
module tb_umi_isolate_ctrl;
  import umi_isolate_pkg::*;

  localparam int N   = 2;
  localparam int CW  = 32;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int WK  = 4;
  localparam int DTO = 8;
  localparam int PW  = CW + 2*AW + DW;

  logic            clk = 1'b0;
  logic            nreset, iso_req, iso_ack, drain_err;
  logic [N-1:0]    umi_in_valid, umi_in_ready, umi_out_valid, umi_out_ready;
  logic [N*CW-1:0] umi_in_cmd, umi_out_cmd;
  logic [N*AW-1:0] umi_in_dstaddr, umi_in_srcaddr, umi_out_dstaddr, umi_out_srcaddr;
  logic [N*DW-1:0] umi_in_data, umi_out_data;

  umi_isolate_ctrl #(.N(N), .CW(CW), .AW(AW), .DW(DW),
                     .WAKE_CYCLES(WK), .DRAIN_TIMEOUT(DTO)) dut (
    .clk(clk), .nreset(nreset), .iso_req(iso_req), .iso_ack(iso_ack), .drain_err(drain_err),
    .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd), .umi_in_dstaddr(umi_in_dstaddr),
    .umi_in_srcaddr(umi_in_srcaddr), .umi_in_data(umi_in_data), .umi_in_ready(umi_in_ready),
    .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd), .umi_out_dstaddr(umi_out_dstaddr),
    .umi_out_srcaddr(umi_out_srcaddr), .umi_out_data(umi_out_data), .umi_out_ready(umi_out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus state: each source holds its payload until it is accepted.
  logic [N-1:0]    src_busy;
  logic [PW-1:0]   pay [N];
  int              vld_pct [N];
  int              rdy_mode [N];   // 0 random, 1 held low, 2 held high
  logic [PW-1:0]   sbq [N][$];
  int              hs_cnt [N];
  logic [N-1:0]    obs_ov;
  logic            obs_ack, obs_err;

  // Behavioural model: which phase the block is in and which channels owe a handshake.
  typedef enum {M_PASS, M_FLUSH, M_HOLD, M_RESUME} mphase_e;
  mphase_e      m_ph;
  logic [N-1:0] m_owed;
  int           m_age, m_left;
  logic         m_ack, m_err;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_pay();
    logic [PW-1:0] v;
    for (int k = 0; k < PW; k += 32) v[k +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [PW-1:0] in_pay(input int i);
    return {umi_in_cmd[i*CW +: CW], umi_in_dstaddr[i*AW +: AW],
            umi_in_srcaddr[i*AW +: AW], umi_in_data[i*DW +: DW]};
  endfunction

  function automatic logic [PW-1:0] out_pay(input int i);
    return {umi_out_cmd[i*CW +: CW], umi_out_dstaddr[i*AW +: AW],
            umi_out_srcaddr[i*AW +: AW], umi_out_data[i*DW +: DW]};
  endfunction

  function automatic logic m_open(input int i);
    return (m_ph == M_PASS) || (m_ph == M_FLUSH && m_owed[i]);
  endfunction

  task automatic model_reset();
    m_ph = M_PASS; m_owed = '0; m_age = 0; m_left = 0; m_ack = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] owed_n;
    owed_n = m_owed;
    for (int i = 0; i < N; i++)
      if (m_open(i) && umi_in_valid[i]) owed_n[i] = !umi_out_ready[i];
    m_ack = (m_ph == M_HOLD);
    case (m_ph)
      M_PASS: begin
        m_owed = owed_n;
        if (iso_req) begin m_ph = M_FLUSH; m_age = 0; end
      end
      M_FLUSH: begin
        m_owed = owed_n;
        m_age++;
        if (owed_n == '0) m_ph = M_HOLD;
        else if (m_age >= DTO) begin m_ph = M_HOLD; m_err = 1'b1; end
      end
      M_HOLD: begin
        m_owed = '0;
        if (!iso_req) begin m_ph = M_RESUME; m_left = WK; end
      end
      default: begin
        m_left--;
        if (iso_req) m_ph = M_HOLD;
        else if (m_left == 0) m_ph = M_PASS;
      end
    endcase
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [PW-1:0] p;
      if (!src_busy[i] && ($urandom_range(99) < vld_pct[i])) begin
        src_busy[i] = 1'b1;
        pay[i] = rand_pay();
      end
      p = src_busy[i] ? pay[i] : rand_pay();
      umi_in_valid[i]             = src_busy[i];
      umi_in_cmd[i*CW +: CW]      = p[DW+2*AW +: CW];
      umi_in_dstaddr[i*AW +: AW]  = p[DW+AW +: AW];
      umi_in_srcaddr[i*AW +: AW]  = p[DW +: AW];
      umi_in_data[i*DW +: DW]     = p[DW-1:0];
      case (rdy_mode[i])
        0:       umi_out_ready[i] = 1'($urandom_range(1));
        1:       umi_out_ready[i] = 1'b0;
        default: umi_out_ready[i] = 1'b1;
      endcase
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < N; i++) begin
      logic op;
      op = m_open(i);
      chk($sformatf("out_valid[%0d]", i), PW'(umi_out_valid[i]), PW'(op & umi_in_valid[i]));
      chk($sformatf("in_ready[%0d]", i), PW'(umi_in_ready[i]), PW'(op & umi_out_ready[i]));
      chk($sformatf("payload[%0d]", i), out_pay(i), op ? in_pay(i) : {PW{1'b0}});
    end
    chk("iso_ack", PW'(iso_ack), PW'(m_ack));
    chk("drain_err", PW'(drain_err), PW'(m_err));
  endtask

  // One clock cycle: check at the falling edge, settle handshakes, then drive the next cycle.
  task automatic tick();
    logic [N-1:0] acc, del;
    #4;
    check_outputs();
    acc = umi_in_valid & umi_in_ready;
    del = umi_out_valid & umi_out_ready;
    obs_ov = umi_out_valid; obs_ack = iso_ack; obs_err = drain_err;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin sbq[i].push_back(pay[i]); src_busy[i] = 1'b0; end
      if (del[i]) begin
        hs_cnt[i]++;
        chk($sformatf("sb_nonempty[%0d]", i), PW'(sbq[i].size() != 0), PW'(1));
        if (sbq[i].size() != 0) chk($sformatf("sb_payload[%0d]", i), out_pay(i), sbq[i].pop_front());
      end
    end
    if (nreset) model_step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic set_mode(input int v0, input int v1, input int r0, input int r1);
    vld_pct[0] = v0; vld_pct[1] = v1; rdy_mode[0] = r0; rdy_mode[1] = r1;
  endtask

  initial begin
    int n;
    nreset = 1'b0; iso_req = 1'b0; src_busy = '0;
    umi_in_valid = '0; umi_out_ready = '0;
    umi_in_cmd = '0; umi_in_dstaddr = '0; umi_in_srcaddr = '0; umi_in_data = '0;
    for (int i = 0; i < N; i++) begin hs_cnt[i] = 0; pay[i] = '0; end
    model_reset();
    set_mode(70, 70, 0, 0);

    // Reset: datapath passes through, flags low.
    @(posedge clk); #1; drive();
    tick(); tick();
    nreset = 1'b1;

    // RUN: random traffic passes through unchanged.
    repeat (30) tick();

    // Drain with channel 0 stalled; released after 5 drain cycles.
    set_mode(100, 100, 1, 2);
    repeat (3) tick();
    iso_req = 1'b1;
    tick();
    hs_cnt[0] = 0;
    tick();
    chk("ch1_masked", PW'(obs_ov[1]), PW'(0));
    repeat (4) tick();
    rdy_mode[0] = 2; umi_out_ready[0] = 1'b1;
    tick();
    chk("ch0_one_hs", PW'(hs_cnt[0]), PW'(1));
    tick();
    chk("iso_entered_ack", PW'(obs_ack), PW'(0));
    chk("iso_entered_clamp", PW'(obs_ov[0]), PW'(0));
    tick();
    chk("iso_ack_high", PW'(obs_ack), PW'(1));
    tick();

    // Release: ISO cycle plus WAKE_CYCLES clamped cycles, then pass-through.
    set_mode(100, 100, 0, 0);
    iso_req = 1'b0;
    n = 0;
    while (n < 20) begin tick(); if (obs_ov[0]) break; n++; end
    chk("clamp_cycles", PW'(n), PW'(1 + WK));

    // Re-isolate during WAKE cycle 2.
    rdy_mode[0] = 2; rdy_mode[1] = 2;
    iso_req = 1'b1;
    n = 0;
    while (n < 20 && !obs_ack) begin tick(); n++; end
    chk("reach_iso", PW'(obs_ack), PW'(1));
    iso_req = 1'b0;
    tick(); tick();
    iso_req = 1'b1;
    tick(); tick(); tick();
    chk("rewake_iso", PW'(obs_ack), PW'(1));
    iso_req = 1'b0;
    set_mode(60, 60, 0, 0);
    repeat (8) tick();

    // Drain timeout with both ready held low.
    set_mode(100, 100, 1, 1);
    repeat (3) tick();
    chk("err_before", PW'(obs_err), PW'(0));
    iso_req = 1'b1;
    tick();
    n = 0;
    while (n < 30) begin tick(); if (!obs_ov[0]) break; n++; end
    chk("drain_cycles", PW'(n), PW'(DTO));
    chk("err_set", PW'(obs_err), PW'(1));
    tick();
    iso_req = 1'b0;
    set_mode(60, 60, 0, 0);
    repeat (10) tick();
    chk("err_sticky", PW'(obs_err), PW'(1));

    // Asynchronous reset in the middle of a drain.
    set_mode(100, 100, 1, 2);
    repeat (3) tick();
    iso_req = 1'b1;
    tick();
    tick(); tick();
    #2 nreset = 1'b0;
    #1;
    chk("rst_state", PW'(dut.state), PW'(RUN));
    chk("rst_pend", PW'(dut.pend), PW'(0));
    chk("rst_err", PW'(drain_err), PW'(0));
    chk("rst_ack", PW'(iso_ack), PW'(0));
    chk("rst_pass", PW'(umi_out_valid[1]), PW'(umi_in_valid[1]));
    model_reset();
    iso_req = 1'b0;
    tick();
    nreset = 1'b1;
    set_mode(70, 70, 0, 0);
    repeat (20) tick();

    for (int i = 0; i < N; i++) chk($sformatf("sb_lost[%0d]", i), PW'(sbq[i].size()), PW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/umi_isolate_ctrl.md
UMI_ISOLATE_CTRL -- requirements
Module: umi_isolate_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- N, 2, number of UMI channels.
- CW, 32, command width.
- AW, 64, address width.
- DW, 256, data width.
- WAKE_CYCLES, 4, clamp hold after release, >=1.
- DRAIN_TIMEOUT, 64, maximum cycles in DRAIN, >=1.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, the one clock.
- nreset, in, 1, asynchronous active-low reset.
- iso_req, in, 1, isolation request (synchronous to clk).
- iso_ack, out, 1, channels clamped.
- drain_err, out, 1, sticky drain-timeout flag.
- umi_in_valid, in, N, upstream valid.
- umi_in_cmd, in, N*CW, upstream cmd.
- umi_in_dstaddr, in, N*AW, upstream dstaddr.
- umi_in_srcaddr, in, N*AW, upstream srcaddr.
- umi_in_data, in, N*DW, upstream data.
- umi_in_ready, out, N, ready to upstream.
- umi_out_valid, out, N, downstream valid.
- umi_out_cmd, out, N*CW, downstream cmd.
- umi_out_dstaddr, out, N*AW, downstream dstaddr.
- umi_out_srcaddr, out, N*AW, downstream srcaddr.
- umi_out_data, out, N*DW, downstream data.
- umi_out_ready, in, N, ready from downstream.
REQ-003 Channel i SHALL occupy slice [i*W +: W] of every packed vector.

Function
REQ-004 The state machine SHALL have four states: RUN, DRAIN, ISO, WAKE.
REQ-005 RUN: all channels pass through combinationally (valid, cmd, addrs, data forward; ready backward); zero latency.
REQ-006 pend[i] SHALL set when umi_out_valid[i] & ~umi_out_ready[i], and clear on a handshake (umi_out_valid[i] & umi_out_ready[i]).
REQ-007 RUN->DRAIN when iso_req=1; the drain counter loads 0.
REQ-008 DRAIN: a channel with pend[i]=1 SHALL pass through unchanged until its handshake; a channel with pend[i]=0 SHALL be masked (out_valid=0, in_ready=0, payload outputs 0).
REQ-009 DRAIN->ISO when all pend bits are 0, including the cycle the last handshake completes (the next state is ISO).
REQ-010 DRAIN SHALL leave for ISO after DRAIN_TIMEOUT cycles even with pend nonzero; drain_err SHALL set and stay set until reset.
REQ-011 ISO: all outputs clamped to 0 for every channel; iso_ack=1; pend cleared.
REQ-012 ISO->WAKE when iso_req=0; the wake counter loads WAKE_CYCLES.
REQ-013 WAKE: outputs stay clamped and iso_ack=0; the counter decrements each cycle; WAKE->RUN when it reaches 0; WAKE->ISO when iso_req=1 (that has priority).
REQ-014 iso_req dropping in DRAIN SHALL NOT abort the drain; the block completes ISO then WAKE.
REQ-015 A transfer accepted on a handshake SHALL never be duplicated, dropped or altered by a state change.
REQ-016 iso_ack SHALL be registered: it goes high the cycle after ISO is entered and low the cycle after ISO is left.
REQ-017 Counters SHALL be sized $clog2(max+1) and SHALL saturate, never wrap.

Reset
REQ-018 nreset low SHALL asynchronously force state RUN, pend=0, counters=0, iso_ack=0, drain_err=0.
REQ-019 Datapath outputs SHALL be combinational from state; while in reset they reflect RUN pass-through.
REQ-020 Reset mid-DRAIN SHALL abandon the drain with no flag set.

Structure
REQ-021 A shared package umi_isolate_pkg SHALL hold the state enum (RUN, DRAIN, ISO, WAKE) and the default constants.
REQ-022 Per-channel gating and clamping SHALL live in one sub-module, umi_isolate_chan, instantiated N times; the FSM and counters sit in the top.

Verification
REQ-023 RUN, N=2, random traffic on both channels: out equals in every cycle; iso_ack=0.
REQ-024 Channel 0 holds valid with ready=0; iso_req=1; release ready after 5 cycles:
- channel 1 is masked immediately;
- channel 0 completes exactly one handshake;
- ISO is entered the next cycle and iso_ack=1 the cycle after.
REQ-025 DRAIN_TIMEOUT=8 with ready held at 0: ISO is entered after 8 DRAIN cycles; drain_err=1 and stays 1 until nreset.
REQ-026 iso_req 1->0 with WAKE_CYCLES=4: outputs stay clamped 4 cycles, then pass-through resumes; iso_req=1 in WAKE cycle 2 returns to ISO.
REQ-027 nreset pulsed low mid-DRAIN: state RUN, pend=0, drain_err=0 immediately, without waiting for a clock edge.
REQ-028 Scoreboard over all scenarios: no transaction lost or duplicated across iso/wake cycles.
